rca_seq_ctrl: RTL and testbench
===============================

// Module: rca_seq_ctrl
// PURPOSE
//  Sequencer that reuses one 4-bit ripple-carry adder slice to add two WIDTH-bit operands one nibble per cycle.
//  - Captures operands on an input valid/ready handshake.
//  - Steps LSB->MSB through the nibbles, chaining the carry through a register.
//  - Presents sum, carry and signed overflow on an output valid/ready handshake.
//  - Sits between a requesting datapath and the shared adder slice; trades latency for area.
// PARAMETERS
//  WIDTH    16   operand/sum width in bits; must be a multiple of 4 and >= 8
//  NUM_NIB  WIDTH/4  derived (localparam), number of nibble steps per add
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand request valid
//  in_ready   out  1      controller can accept operands
//  a          in   WIDTH  operand A, sampled on in_valid && in_ready
//  b          in   WIDTH  operand B, sampled on in_valid && in_ready
//  cin        in   1      carry-in to nibble 0, sampled with a/b
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  a + b + cin, low WIDTH bits
//  cout       out  1      carry out of the MSB nibble
//  ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
//  busy       out  1      high in ADD or DONE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; in_ready=1; out_valid=0; busy=0.
//   - sum, cout, ovf, nibble counter, carry register and operand registers all 0.
//  FSM, transitions on the clk edge:
//   - IDLE: in_ready=1. On in_valid: latch a, b, cin; cnt=0; go to ADD.
//   - ADD: in_ready=0. Each cycle the slice adds a[4k+3:4k] + b[4k+3:4k] + carry_reg, k=cnt.
//     - The slice output is written to sum[4k+3:4k]; carry_reg takes the slice carry; cnt increments.
//     - At k=NUM_NIB-1: cout takes the slice carry; ovf = c3^c4 of the MSB slice; go to DONE.
//   - DONE: out_valid=1. Hold until out_ready, then go to IDLE with out_valid=0.
//  Latency and throughput:
//   - Accept in cycle T; out_valid rises at T+NUM_NIB+1 (16-bit: T+5).
//   - Minimum spacing between accepts is NUM_NIB+2 cycles.
//  Output stability:
//   - sum, cout and ovf are stable and valid only while out_valid=1.
//   - While out_valid=1 and out_ready=0 they must not change.
//   - They hold their last values after the handshake, until the next ADD overwrites them.
//  Handshake rules:
//   - in_valid while busy is ignored: no capture, no error.
//   - out_ready while out_valid=0 has no effect.
//   - No combinational path from in_valid to in_ready or from out_ready to out_valid.
//  Arithmetic:
//   - Unsigned modulo 2^WIDTH with carry out.
//   - ovf is meaningful for two's-complement operands.
//   - Carry enters only nibble 0 from cin; every later nibble takes carry_reg.
//  Boundaries:
//   - Counter is clog2(NUM_NIB) bits wide and must not wrap within an operation.
//   - Reset asserted in ADD or DONE aborts the add immediately to the reset state; no partial result is flagged valid.
// STRUCTURE
//  - Shared package rca_pkg: state enum {IDLE, ADD, DONE}, NIB_W=4.
//  - Sub-module rca_nibble: purely combinational 4-bit ripple-carry slice (a, b, ci -> s, co, c3).
//    - c3 is the carry into bit 3, used for ovf.
//    - Built from four full-adder stages; instantiated once and muxed by cnt.
// TESTING (WIDTH=16)
//  1. a=0x5555, b=0x3333, cin=0 -> sum=0x8888, cout=0, ovf=1, out_valid 5 cycles after accept.
//  2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; carry ripples through all 4 nibbles.
//  3. a=0x8000, b=0x7FFF, cin=1 -> sum=0x0000, cout=1, ovf=0. Then a=0xA000, b=0xC000, cin=0 -> sum=0x6000, cout=1, ovf=1.
//  4. Backpressure: hold out_ready=0 for 3 cycles in DONE, with in_valid=1 and new operands present.
//     -> sum, cout, ovf stable; in_ready=0; new operands not captured until after the handshake.
//  5. Drop rst_n mid-ADD (after 2 nibbles) -> outputs immediately at reset values.
//     -> After release, a fresh add 0x0000+0x0000, cin=1 gives sum=0x0001.
//  6. Back-to-back: in_valid held high across two requests -> second accepted only in IDLE; both results correct.

Source files
------------

// File: rtl/rca_pkg.sv
// rca_pkg: shared state encoding and slice width for the nibble-serial adder
package rca_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  localparam int NIB_W = 4;
endpackage

// File: rtl/rca_nibble.sv
// rca_nibble: combinational 4-bit ripple-carry slice; c3 is the carry into the top bit
module rca_nibble
  import rca_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co,
  output logic             c3
);
  logic [NIB_W:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[NIB_W];
  assign c3 = c[NIB_W-1];
endmodule

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: adds two WIDTH-bit operands one nibble per cycle through a single shared slice
module rca_seq_ctrl
  import rca_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NUM_NIB = WIDTH / NIB_W;
  localparam int CNT_W   = $clog2(NUM_NIB);
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry;
  logic [NIB_W-1:0] nib_s;
  logic             nib_co, nib_c3;
  logic             last;
  assign last      = cnt == CNT_W'(NUM_NIB - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  rca_nibble u_nib (
    .a  (a_q[cnt*NIB_W +: NIB_W]),
    .b  (b_q[cnt*NIB_W +: NIB_W]),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co),
    .c3 (nib_c3)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid  ? ADD  : IDLE;
      ADD:     state_nx = last      ? DONE : ADD;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // cin is parked in the carry register so nibble 0 sees it like every later nibble sees its chain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_q   <= a;
      b_q   <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == ADD) begin
      sum[cnt*NIB_W +: NIB_W] <= nib_s;
      carry                   <= nib_co;
      if (last) begin
        cout <= nib_co;
        ovf  <= nib_c3 ^ nib_co;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb_rca_seq_ctrl: directed self-checking bench for the 16-bit nibble-serial adder
module tb_rca_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;
  int          errors = 0;
  int          checks = 0;

  rca_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Called at a negedge with the DUT idle; returns result and cycles from accept to out_valid.
  task automatic do_add(input logic [15:0] op_a, op_b, input logic op_c,
                        output logic [15:0] s, output logic co, ov, output int lat);
    in_valid = 1'b1; a = op_a; b = op_b; cin = op_c;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s = sum; co = cout; ov = ovf;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (sum !== 16'h0000)   begin errors++; $display("FAIL reset_sum got %h exp 0000", sum); end
    checks++; if (cout !== 1'b0)      begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
    checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arith;
    logic [15:0] va [4] = '{16'h5555, 16'hFFFF, 16'h8000, 16'hA000};
    logic [15:0] vb [4] = '{16'h3333, 16'h0001, 16'h7FFF, 16'hC000};
    logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] es [4] = '{16'h8888, 16'h0000, 16'h0000, 16'h6000};
    logic        ec [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        eo [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] s;
    logic        co, ov;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      do_add(va[i], vb[i], vc[i], s, co, ov, lat);
      checks++; if (lat !== 5)    begin errors++; $display("FAIL arith%0d_latency got %0d exp 5", i, lat); end
      checks++; if (s !== es[i])  begin errors++; $display("FAIL arith%0d_sum got %h exp %h", i, s, es[i]); end
      checks++; if (co !== ec[i]) begin errors++; $display("FAIL arith%0d_cout got %b exp %b", i, co, ec[i]); end
      checks++; if (ov !== eo[i]) begin errors++; $display("FAIL arith%0d_ovf got %b exp %b", i, ov, eo[i]); end
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
        begin errors++; $display("FAIL arith%0d_post_handshake got ov=%b ir=%b exp 0 1", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0;
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat !== 5) begin errors++; $display("FAIL bp_first_latency got %0d exp 5", lat); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (sum !== 16'h2345 || cout !== 1'b0 || ovf !== 1'b0)
        begin errors++; $display("FAIL bp_hold%0d got %h/%b/%b exp 2345/0/0", i, sum, cout, ovf); end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
        begin errors++; $display("FAIL bp_flags%0d got ir=%b ov=%b exp 0 1", i, in_ready, out_valid); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || sum !== 16'h2345)
      begin errors++; $display("FAIL bp_idle got ir=%b sum=%h exp 1 2345", in_ready, sum); end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat !== 5) begin errors++; $display("FAIL bp_second_latency got %0d exp 5", lat); end
    checks++; if (sum !== 16'h1010 || cout !== 1'b0 || ovf !== 1'b0)
      begin errors++; $display("FAIL bp_second_result got %h/%b/%b exp 1010/0/0", sum, cout, ovf); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_add;
    logic [15:0] s;
    logic        co, ov;
    int          lat;
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1 || sum[7:0] !== 8'h33)
      begin errors++; $display("FAIL abort_partial got busy=%b sum=%h exp 1 xx33", busy, sum); end
    rst_n = 1'b0;
    #1;
    checks++; if (sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0)
      begin errors++; $display("FAIL abort_outputs got %h/%b/%b exp 0000/0/0", sum, cout, ovf); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL abort_flags got ov=%b busy=%b ir=%b exp 0 0 1", out_valid, busy, in_ready); end
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_held got %b exp 0", out_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    do_add(16'h0000, 16'h0000, 1'b1, s, co, ov, lat);
    checks++; if (lat !== 5 || s !== 16'h0001 || co !== 1'b0 || ov !== 1'b0)
      begin errors++; $display("FAIL abort_fresh_add got lat=%0d %h/%b/%b exp 5 0001/0/0", lat, s, co, ov); end
  endtask

  task automatic test_back_to_back;
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h7FFF; b = 16'h0001; cin = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    lat = 1;
    while (!out_valid && lat < 20) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_add got %b exp 0", in_ready); end
      @(negedge clk); lat++;
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_first_latency got %0d exp 5", lat); end
    checks++; if (sum !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1)
      begin errors++; $display("FAIL b2b_first_result got %h/%b/%b exp 8000/0/1", sum, cout, ovf); end
    lat = 0;
    @(negedge clk); lat++;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got %b exp 1", in_ready); end
    @(negedge clk); lat++;
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat !== 6) begin errors++; $display("FAIL b2b_spacing got %0d exp 6", lat); end
    checks++; if (sum !== 16'hFFFF || cout !== 1'b1 || ovf !== 1'b0)
      begin errors++; $display("FAIL b2b_second_result got %h/%b/%b exp ffff/1/0", sum, cout, ovf); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_done got %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_backpressure;
    test_reset_mid_add;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
